// File: rtl/msrv32_pc_src_ctrl_if.sv
// Side-band bundle between the PC-source controller and the control unit, CSR file and PC mux.
// The master modport is the controller; the slave modport is the surrounding core.
interface msrv32_pc_src_ctrl_if;
  logic       ahb_ready_in;
  logic       trap_req_in;
  logic       mret_in;
  logic       misaligned_instr_in;
  logic [1:0] pc_src_out;
  logic       fetch_en_out;
  logic       flush_out;
  logic       trap_taken_out;
  logic       mret_done_out;
  logic       misalign_cause_out;
  logic [2:0] state_out;

  modport master (
    input  ahb_ready_in,
    input  trap_req_in,
    input  mret_in,
    input  misaligned_instr_in,
    output pc_src_out,
    output fetch_en_out,
    output flush_out,
    output trap_taken_out,
    output mret_done_out,
    output misalign_cause_out,
    output state_out
  );

  modport slave (
    output ahb_ready_in,
    output trap_req_in,
    output mret_in,
    output misaligned_instr_in,
    input  pc_src_out,
    input  fetch_en_out,
    input  flush_out,
    input  trap_taken_out,
    input  mret_done_out,
    input  misalign_cause_out,
    input  state_out
  );
endinterface

// File: rtl/msrv32_pc_src_ctrl.sv
// PC-source sequencer: boot, run, trap-entry and MRET-return phases driving the PC mux select.
// Optional feature macro MSRV32_MISALIGN_TRAP_EN turns a misaligned fetch in RUN into a trap.
module msrv32_pc_src_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  msrv32_pc_src_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_BOOT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_TRAP  = 3'd3,
    ST_MRET  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic             trap_pend_q, trap_pend_d;
  logic             misalign_q, misalign_d;
  logic             trap_first_q, trap_first_d;
  logic             run_trap;
  logic             run_misalign;

`ifdef MSRV32_MISALIGN_TRAP_EN
  assign run_trap     = bus.trap_req_in | bus.misaligned_instr_in;
  assign run_misalign = bus.misaligned_instr_in;
`else
  logic unused_misaligned;
  assign unused_misaligned = bus.misaligned_instr_in;
  assign run_trap          = bus.trap_req_in;
  assign run_misalign      = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    trap_pend_d  = trap_pend_q;
    misalign_d   = misalign_q;
    trap_first_d = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_BOOT;
      ST_BOOT: begin
        if (bus.ahb_ready_in) begin
          if (boot_cnt_q == BOOT_LAST) begin
            state_d    = ST_RUN;
            boot_cnt_d = '0;
          end else begin
            boot_cnt_d = boot_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        // A trap request outranks a simultaneous MRET, which is simply dropped.
        if (run_trap) begin
          state_d      = ST_TRAP;
          trap_first_d = 1'b1;
          misalign_d   = run_misalign;
        end else if (bus.mret_in) begin
          state_d = ST_MRET;
        end
      end
      ST_TRAP: begin
        if (bus.ahb_ready_in) begin
          misalign_d = 1'b0;
          if (trap_pend_q) begin
            state_d      = ST_TRAP;
            trap_first_d = 1'b1;
            trap_pend_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_MRET: begin
        if (bus.trap_req_in) begin
          trap_pend_d = 1'b1;
        end
        if (bus.ahb_ready_in) begin
          if (trap_pend_q || bus.trap_req_in) begin
            state_d      = ST_TRAP;
            trap_first_d = 1'b1;
            trap_pend_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= ST_RESET;
      boot_cnt_q   <= '0;
      trap_pend_q  <= 1'b0;
      misalign_q   <= 1'b0;
      trap_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      trap_pend_q  <= trap_pend_d;
      misalign_q   <= misalign_d;
      trap_first_q <= trap_first_d;
    end
  end

  always_comb begin
    bus.pc_src_out   = 2'b00;
    bus.fetch_en_out = 1'b0;
    bus.flush_out    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        bus.pc_src_out   = 2'b00;
        bus.fetch_en_out = 1'b1;
      end
      ST_RUN: begin
        bus.pc_src_out   = 2'b11;
        bus.fetch_en_out = 1'b1;
      end
      ST_TRAP: begin
        bus.pc_src_out   = 2'b10;
        bus.fetch_en_out = 1'b1;
        bus.flush_out    = 1'b1;
      end
      ST_MRET: begin
        bus.pc_src_out   = 2'b01;
        bus.fetch_en_out = 1'b1;
        bus.flush_out    = 1'b1;
      end
      default: begin
        bus.pc_src_out   = 2'b00;
        bus.fetch_en_out = 1'b0;
        bus.flush_out    = 1'b0;
      end
    endcase
  end

  // MRET completion can only be known in the cycle the bus accepts, so ready gates the pulse.
  assign bus.mret_done_out      = (state_q == ST_MRET) && bus.ahb_ready_in;
  assign bus.trap_taken_out     = trap_first_q;
  assign bus.misalign_cause_out = misalign_q;
  assign bus.state_out          = state_q;

endmodule

// File: tb/tb_msrv32_pc_src_ctrl.sv
// Directed bench for msrv32_pc_src_ctrl: boot, trap stall, trap/MRET priority, MRET with
// pending trap, reset mid-trap and misaligned-fetch handling (MSRV32_MISALIGN_TRAP_EN aware).
module tb_msrv32_pc_src_ctrl;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  msrv32_pc_src_ctrl_if bus ();

  msrv32_pc_src_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic rdy, input logic trap,
                               input logic mret, input logic mis);
    rst                     = r;
    bus.ahb_ready_in        = rdy;
    bus.trap_req_in         = trap;
    bus.mret_in             = mret;
    bus.misaligned_instr_in = mis;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full output snapshot against hand-computed values.
  task automatic checkAll(input string tag, input logic [2:0] st, input logic [1:0] pc,
                          input logic fe, input logic fl, input logic tt, input logic md,
                          input logic mc);
    checkOutput({tag, ".state"},      8'(bus.state_out),          8'(st));
    checkOutput({tag, ".pc_src"},     8'(bus.pc_src_out),         8'(pc));
    checkOutput({tag, ".fetch_en"},   8'(bus.fetch_en_out),       8'(fe));
    checkOutput({tag, ".flush"},      8'(bus.flush_out),          8'(fl));
    checkOutput({tag, ".trap_taken"}, 8'(bus.trap_taken_out),     8'(tt));
    checkOutput({tag, ".mret_done"},  8'(bus.mret_done_out),      8'(md));
    checkOutput({tag, ".misalign"},   8'(bus.misalign_cause_out), 8'(mc));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset and boot
    applyStimulus(0, 1, 0, 0, 0);
    tick; tick; tick;
    checkAll("rst_hold", 3'd0, 2'b00, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("rel_c1", 3'd0, 2'b00, 0, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 1, 1, 0);
    checkAll("boot_c2", 3'd1, 2'b00, 1, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("boot_c3", 3'd1, 2'b00, 1, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("run_c4", 3'd2, 2'b11, 1, 0, 0, 0, 0);

    // Trap with bus stall; a second request during TRAP must be ignored
    applyStimulus(1, 0, 1, 0, 0);
    tick;
    applyStimulus(1, 0, 0, 0, 0);
    checkAll("trap_n1", 3'd3, 2'b10, 1, 1, 1, 0, 0);
    tick;
    applyStimulus(1, 0, 1, 1, 0);
    checkAll("trap_n2", 3'd3, 2'b10, 1, 1, 0, 0, 0);
    tick;
    applyStimulus(1, 0, 0, 0, 0);
    checkAll("trap_n3", 3'd3, 2'b10, 1, 1, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("trap_n4", 3'd3, 2'b10, 1, 1, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("trap_n5", 3'd2, 2'b11, 1, 0, 0, 0, 0);

    // Simultaneous trap and MRET: trap wins
    applyStimulus(1, 1, 1, 1, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("both_trap", 3'd3, 2'b10, 1, 1, 1, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("both_run", 3'd2, 2'b11, 1, 0, 0, 0, 0);

    // Trap request while MRET waits for the bus
    applyStimulus(1, 0, 0, 1, 0);
    tick;
    applyStimulus(1, 0, 1, 0, 0);
    checkAll("mret_c1", 3'd4, 2'b01, 1, 1, 0, 0, 0);
    tick;
    applyStimulus(1, 0, 0, 0, 0);
    checkAll("mret_c2", 3'd4, 2'b01, 1, 1, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("mret_c3", 3'd4, 2'b01, 1, 1, 0, 1, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("mret_trap", 3'd3, 2'b10, 1, 1, 1, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("mret_run", 3'd2, 2'b11, 1, 0, 0, 0, 0);

    // Reset in the second TRAP cycle, then a boot with one stalled cycle
    applyStimulus(1, 0, 1, 0, 0);
    tick;
    applyStimulus(1, 0, 0, 0, 0);
    tick;
    applyStimulus(0, 0, 0, 0, 0);
    checkAll("mid_trap2", 3'd3, 2'b10, 1, 1, 0, 0, 0);
    tick;
    applyStimulus(1, 0, 0, 0, 0);
    checkAll("mid_rst", 3'd0, 2'b00, 0, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 0, 0, 0, 0);
    checkAll("reboot_c1", 3'd1, 2'b00, 1, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("reboot_stall", 3'd1, 2'b00, 1, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("reboot_c3", 3'd1, 2'b00, 1, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("reboot_run", 3'd2, 2'b11, 1, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 0, 0, 0, 0);
    checkAll("lost_pend", 3'd2, 2'b11, 1, 0, 0, 0, 0);

    // Misaligned fetch in RUN
    applyStimulus(1, 0, 0, 0, 1);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
`ifdef MSRV32_MISALIGN_TRAP_EN
    checkAll("mis_trap", 3'd3, 2'b10, 1, 1, 1, 0, 1);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("mis_exit", 3'd2, 2'b11, 1, 0, 0, 0, 0);
`else
    checkAll("mis_ignored", 3'd2, 2'b11, 1, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    checkAll("mis_still_run", 3'd2, 2'b11, 1, 0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
